// File: rtl/risc_cunit.sv
// risc_cunit - multicycle control unit for the 13-bit RISC core.
//
// Sequences the instruction unit through fetch, decode, execute and
// writeback. Drives the instruction-unit strobes (ir_ld, pc_inc, pc_ld),
// the ALU opcode and the register-file addresses / write enable.
//
// Ports:
//   clk, rst_n            system clock, asynchronous active-low reset
//   start                 begin execution from IDLE or HALT (level)
//   ir[12:0]              instruction register: op[12:9] rd[8:6]
//                         rs1[5:3] rs2[2:0], jump target [4:0]
//   imem_ack              instruction word is on the iunit bus
//   imem_req              fetch request (FETCH)
//   ir_ld                 iunit loads ir (FETCH & imem_ack)
//   pc_inc / pc_ld        iunit pc increment / load from pc_target
//   pc_target[4:0]        jump target
//   alu_op[3:0]           latched opcode
//   rf_ra/rf_rb/rf_wa     register-file addresses (rs1 / rs2 / rd)
//   rf_we                 register-file write enable (WB only)
//   busy / halted         FETCH..WB / HALT
//   retire_cnt            retired-instruction counter, wraps
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | after reset, waits for start
// FETCH   | imem_req high; waits for imem_ack, then ir is loaded
// DECODE  | ir fields captured into the latched-field registers
// EXECUTE | ALU inputs valid; NOP/HLT bump pc, JMP loads pc
// WB      | register-file write, pc increment
// HALT    | stopped after HLT; start resumes at the next pc

module risc_cunit #(
    parameter int RETIRE_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [12:0]         ir,
    input  logic                imem_ack,
    output logic                imem_req,
    output logic                ir_ld,
    output logic                pc_inc,
    output logic                pc_ld,
    output logic [4:0]          pc_target,
    output logic [3:0]          alu_op,
    output logic [2:0]          rf_ra,
    output logic [2:0]          rf_rb,
    output logic [2:0]          rf_wa,
    output logic                rf_we,
    output logic                busy,
    output logic                halted,
    output logic [RETIRE_W-1:0] retire_cnt
);

    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_JMP = 4'd14;
    localparam logic [3:0] OP_HLT = 4'd15;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_EXECUTE = 3'd3,
        S_WB      = 3'd4,
        S_HALT    = 3'd5
    } state_t;

    state_t state_q, state_d;

    logic [3:0] opcode_q, opcode_d;
    logic [2:0] rd_q, rd_d;
    logic [2:0] rs1_q, rs1_d;
    logic [2:0] rs2_q, rs2_d;
    logic [4:0] target_q, target_d;

    logic [RETIRE_W-1:0] retire_q, retire_d;

    logic imem_req_q, imem_req_d;
    logic pc_inc_q, pc_inc_d;
    logic pc_ld_q, pc_ld_d;
    logic rf_we_q, rf_we_d;
    logic busy_q, busy_d;
    logic halted_q, halted_d;

    logic op_is_alu;
    logic op_d_is_alu;

    assign op_is_alu   = (opcode_q != OP_NOP) && (opcode_q < OP_JMP);
    assign op_d_is_alu = (opcode_d != OP_NOP) && (opcode_d < OP_JMP);

    // Next state, latched fields and retire counter.
    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
        rd_d     = rd_q;
        rs1_d    = rs1_q;
        rs2_d    = rs2_q;
        target_d = target_q;
        retire_d = retire_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (imem_ack) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                opcode_d = ir[12:9];
                rd_d     = ir[8:6];
                rs1_d    = ir[5:3];
                rs2_d    = ir[2:0];
                target_d = ir[4:0];
                state_d  = S_EXECUTE;
            end
            S_EXECUTE: begin
                if (op_is_alu) begin
                    state_d = S_WB;
                end else begin
                    // NOP, JMP and HLT retire here; ALU ops retire in WB.
                    retire_d = retire_q + RETIRE_W'(1);
                    state_d  = (opcode_q == OP_HLT) ? S_HALT : S_FETCH;
                end
            end
            S_WB: begin
                retire_d = retire_q + RETIRE_W'(1);
                state_d  = S_FETCH;
            end
            S_HALT: begin
                if (start) begin
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Moore outputs for the state being entered, so each registered
    // strobe is valid for exactly the cycle the FSM spends in that state.
    always_comb begin
        imem_req_d = (state_d == S_FETCH);
        busy_d     = (state_d == S_FETCH)   || (state_d == S_DECODE) ||
                     (state_d == S_EXECUTE) || (state_d == S_WB);
        halted_d   = (state_d == S_HALT);
        rf_we_d    = (state_d == S_WB);
        pc_ld_d    = (state_d == S_EXECUTE) && (opcode_d == OP_JMP);
        pc_inc_d   = (state_d == S_WB) ||
                     ((state_d == S_EXECUTE) && !op_d_is_alu &&
                      (opcode_d != OP_JMP));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            opcode_q   <= '0;
            rd_q       <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            target_q   <= '0;
            retire_q   <= '0;
            imem_req_q <= 1'b0;
            pc_inc_q   <= 1'b0;
            pc_ld_q    <= 1'b0;
            rf_we_q    <= 1'b0;
            busy_q     <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            opcode_q   <= opcode_d;
            rd_q       <= rd_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            target_q   <= target_d;
            retire_q   <= retire_d;
            imem_req_q <= imem_req_d;
            pc_inc_q   <= pc_inc_d;
            pc_ld_q    <= pc_ld_d;
            rf_we_q    <= rf_we_d;
            busy_q     <= busy_d;
            halted_q   <= halted_d;
        end
    end

    // ir_ld is the only output that follows an input within the cycle.
    assign ir_ld      = (state_q == S_FETCH) && imem_ack;

    assign imem_req   = imem_req_q;
    assign pc_inc     = pc_inc_q;
    assign pc_ld      = pc_ld_q;
    assign rf_we      = rf_we_q;
    assign busy       = busy_q;
    assign halted     = halted_q;
    assign retire_cnt = retire_q;

    // Field outputs come straight from the latched registers; they are
    // meaningful in EXECUTE and held through WB.
    assign alu_op     = opcode_q;
    assign rf_ra      = rs1_q;
    assign rf_rb      = rs2_q;
    assign rf_wa      = rd_q;
    assign pc_target  = target_q;

endmodule

// File: tb/tb_risc_cunit.sv
module tb_risc_cunit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [12:0] ir_q;
    logic        imem_ack;
    logic        imem_req;
    logic        ir_ld;
    logic        pc_inc;
    logic        pc_ld;
    logic [4:0]  pc_target;
    logic [3:0]  alu_op;
    logic [2:0]  rf_ra;
    logic [2:0]  rf_rb;
    logic [2:0]  rf_wa;
    logic        rf_we;
    logic        busy;
    logic        halted;
    logic [7:0]  retire_cnt;

    risc_cunit #(.RETIRE_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .ir         (ir_q),
        .imem_ack   (imem_ack),
        .imem_req   (imem_req),
        .ir_ld      (ir_ld),
        .pc_inc     (pc_inc),
        .pc_ld      (pc_ld),
        .pc_target  (pc_target),
        .alu_op     (alu_op),
        .rf_ra      (rf_ra),
        .rf_rb      (rf_rb),
        .rf_wa      (rf_wa),
        .rf_we      (rf_we),
        .busy       (busy),
        .halted     (halted),
        .retire_cnt (retire_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction-unit and instruction-memory model.
    logic [12:0] imem [32];
    logic [4:0]  pc;
    logic        pc_clr;
    logic [4:0]  pc_init;

    always @(posedge clk) begin
        if (pc_clr) begin
            pc <= pc_init;
        end else if (pc_ld) begin
            pc <= pc_target;
        end else if (pc_inc) begin
            pc <= pc + 5'd1;
        end
        if (ir_ld) begin
            ir_q <= imem[pc];
        end
    end

    typedef struct {
        logic [12:0] instr;
        logic [3:0]  op;
        logic [2:0]  ra;
        logic [2:0]  rb;
        logic [2:0]  wa;
    } vec_t;

    vec_t tbl [13];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_imem();
        for (int i = 0; i < 32; i++) imem[i] = 13'h0000;
    endtask

    task automatic do_reset(input logic [4:0] pc0);
        rst_n   = 1'b0;
        start   = 1'b0;
        pc_init = pc0;
        pc_clr  = 1'b1;
        step();
        step();
        pc_clr  = 1'b0;
        rst_n   = 1'b1;
    endtask

    task automatic start_pulse();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Entered in a FETCH cycle with imem_ack high; leaves one sample after
    // the instruction's last cycle.
    task automatic exec(input string nm, input logic [3:0] op, input logic [2:0] ra,
                        input logic [2:0] rb, input logic [2:0] wa,
                        input logic [4:0] tgt, input logic poke_start);
        logic alu;
        alu = (op >= 4'd1) && (op <= 4'd13);
        chk({nm, " fetch imem_req"}, imem_req, 1);
        chk({nm, " fetch ir_ld"}, ir_ld, 1);
        chk({nm, " fetch strobes"}, {pc_inc, pc_ld, rf_we}, 0);
        step();
        if (poke_start) start = 1'b1;
        chk({nm, " decode busy"}, busy, 1);
        chk({nm, " decode strobes"}, {imem_req, ir_ld, pc_inc, pc_ld, rf_we}, 0);
        step();
        start = 1'b0;
        chk({nm, " exec alu_op"}, alu_op, op);
        chk({nm, " exec rf_ra"}, rf_ra, ra);
        chk({nm, " exec rf_rb"}, rf_rb, rb);
        chk({nm, " exec rf_we/imem_req"}, {rf_we, imem_req}, 0);
        if (alu) begin
            chk({nm, " exec pc strobes"}, {pc_inc, pc_ld}, 0);
            step();
            chk({nm, " wb rf_we"}, rf_we, 1);
            chk({nm, " wb rf_wa"}, rf_wa, wa);
            chk({nm, " wb pc_inc/pc_ld"}, {pc_inc, pc_ld}, 2'b10);
            chk({nm, " wb held alu_op"}, alu_op, op);
            chk({nm, " wb held ra/rb"}, {rf_ra, rf_rb}, {ra, rb});
        end else if (op == 4'd14) begin
            chk({nm, " exec pc_ld/pc_inc"}, {pc_ld, pc_inc}, 2'b10);
            chk({nm, " exec pc_target"}, pc_target, tgt);
        end else begin
            chk({nm, " exec pc_inc/pc_ld"}, {pc_inc, pc_ld}, 2'b10);
        end
        step();
        chk({nm, " after strobes"}, {rf_we, pc_inc, pc_ld}, 0);
        if (op == 4'd15) begin
            chk({nm, " halted/busy"}, {halted, busy}, 2'b10);
        end else begin
            chk({nm, " next fetch"}, {imem_req, busy}, 2'b11);
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        imem_ack = 1'b1;
        pc_clr   = 1'b0;
        pc_init  = 5'd0;

        tbl[0]  = '{13'h0208, 4'd1,  3'd1, 3'd0, 3'd0};
        tbl[1]  = '{13'h05f1, 4'd2,  3'd6, 3'd1, 3'd7};
        tbl[2]  = '{13'h06aa, 4'd3,  3'd5, 3'd2, 3'd2};
        tbl[3]  = '{13'h08e3, 4'd4,  3'd4, 3'd3, 3'd3};
        tbl[4]  = '{13'h0b24, 4'd5,  3'd4, 3'd4, 3'd4};
        tbl[5]  = '{13'h0d45, 4'd6,  3'd0, 3'd5, 3'd5};
        tbl[6]  = '{13'h0f86, 4'd7,  3'd0, 3'd6, 3'd6};
        tbl[7]  = '{13'h11c7, 4'd8,  3'd0, 3'd7, 3'd7};
        tbl[8]  = '{13'h1200, 4'd9,  3'd0, 3'd0, 3'd0};
        tbl[9]  = '{13'h1441, 4'd10, 3'd0, 3'd1, 3'd1};
        tbl[10] = '{13'h1682, 4'd11, 3'd0, 3'd2, 3'd2};
        tbl[11] = '{13'h18c3, 4'd12, 3'd0, 3'd3, 3'd3};
        tbl[12] = '{13'h1b04, 4'd13, 3'd0, 3'd4, 3'd4};

        // ALU program: ADD..ROL at pc 0..12, HLT at 13.
        clear_imem();
        for (int i = 0; i < 13; i++) imem[i] = tbl[i].instr;
        imem[13] = 13'h1E00;
        do_reset(5'd0);
        chk("reset busy/halted", {busy, halted}, 0);
        chk("reset strobes", {imem_req, ir_ld, pc_inc, pc_ld, rf_we}, 0);
        chk("reset fields", {alu_op, rf_ra, rf_rb, rf_wa, pc_target}, 0);
        chk("reset retire_cnt", retire_cnt, 0);
        start_pulse();
        for (int i = 0; i < 13; i++) begin
            exec($sformatf("alu%0d", i), tbl[i].op, tbl[i].ra, tbl[i].rb,
                 tbl[i].wa, 5'd0, 1'b0);
            if (i == 0) begin
                chk("add pc", pc, 1);
                chk("add retire_cnt", retire_cnt, 1);
            end
        end
        chk("alu seq pc", pc, 13);
        chk("alu seq retire_cnt", retire_cnt, 13);
        exec("hlt13", 4'd15, 3'd0, 3'd0, 3'd0, 5'd0, 1'b0);
        chk("hlt13 pc", pc, 14);
        chk("hlt13 retire_cnt", retire_cnt, 14);

        // Fetch stall: imem_ack low for 3 cycles.
        clear_imem();
        imem[0] = 13'h0b24;
        imem[1] = 13'h1E00;
        do_reset(5'd0);
        imem_ack = 1'b0;
        start_pulse();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("stall%0d imem_req", k), imem_req, 1);
            chk($sformatf("stall%0d ir_ld", k), ir_ld, 0);
            chk($sformatf("stall%0d strobes", k), {pc_inc, pc_ld, rf_we}, 0);
            step();
        end
        imem_ack = 1'b1;
        #1;
        exec("stall xor", 4'd5, 3'd4, 3'd4, 3'd4, 5'd0, 1'b0);
        exec("stall hlt", 4'd15, 3'd0, 3'd0, 3'd0, 5'd0, 1'b0);
        chk("stall pc", pc, 2);
        chk("stall retire_cnt", retire_cnt, 2);

        // JMP to 30, NOPs at 30 and 31, pc wraps to 0 where HLT sits.
        clear_imem();
        imem[5]  = 13'h1C1E;
        imem[30] = 13'h0000;
        imem[31] = 13'h0000;
        imem[0]  = 13'h1E00;
        do_reset(5'd5);
        start_pulse();
        exec("jmp", 4'd14, 3'd3, 3'd6, 3'd0, 5'd30, 1'b0);
        chk("jmp pc", pc, 30);
        exec("nop30", 4'd0, 3'd0, 3'd0, 3'd0, 5'd0, 1'b0);
        chk("nop30 pc", pc, 31);
        exec("nop31", 4'd0, 3'd0, 3'd0, 3'd0, 5'd0, 1'b0);
        chk("wrap pc", pc, 0);
        exec("hlt0", 4'd15, 3'd0, 3'd0, 3'd0, 5'd0, 1'b0);
        chk("jmp prog pc", pc, 1);
        chk("jmp prog retire_cnt", retire_cnt, 4);

        // HLT at 3, resume at 4, start while busy is ignored.
        clear_imem();
        imem[3] = 13'h1E00;
        imem[4] = 13'h0208;
        imem[5] = 13'h1E00;
        do_reset(5'd3);
        start_pulse();
        exec("hlt3", 4'd15, 3'd0, 3'd0, 3'd0, 5'd0, 1'b0);
        chk("hlt3 pc", pc, 4);
        chk("hlt3 retire_cnt", retire_cnt, 1);
        for (int k = 0; k < 3; k++) step();
        chk("halt hold", {halted, busy, imem_req}, 3'b100);
        chk("halt hold pc", pc, 4);
        start_pulse();
        exec("resume add", 4'd1, 3'd1, 3'd0, 3'd0, 5'd0, 1'b1);
        chk("resume pc", pc, 5);
        exec("hlt5", 4'd15, 3'd0, 3'd0, 3'd0, 5'd0, 1'b0);
        chk("hlt5 pc", pc, 6);
        chk("hlt5 retire_cnt", retire_cnt, 3);

        // Reset in the middle of WB of an ADD.
        clear_imem();
        imem[0] = 13'h0208;
        do_reset(5'd0);
        start_pulse();
        step();
        step();
        step();
        chk("pre-reset wb", {rf_we, pc_inc}, 2'b11);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async reset strobes", {rf_we, pc_inc, pc_ld, imem_req}, 0);
        chk("async reset busy", {busy, halted}, 0);
        chk("async reset retire_cnt", retire_cnt, 0);
        chk("async reset alu_op", alu_op, 0);
        step();
        chk("reset pc held", pc, 0);
        rst_n = 1'b1;
        step();
        chk("idle after reset", {busy, imem_req, halted}, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
